// File: rtl/uart_rx_fsm_core_pkg.sv
// Shared UART definitions: FSM states, prescale and parity constants.
// Also used by the TX side of the UART block.
package uart_rx_fsm_core_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fsm_core_sampler.sv
// Per-bit edge counter, three-sample majority vote and end-of-bit strobe.
// sampled_bit is valid from edge prescale/2+2 until the next vote.
module uart_rx_sampler
  import uart_rx_fsm_core_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  rx_in,
  output logic                  sampled_bit,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last_edge;
  logic                  s0;
  logic                  s1;
  logic                  at_lo;
  logic                  at_mid;
  logic                  at_hi;

  assign half      = prescale >> 1;
  assign last_edge = prescale - PRESCALE_W'(1);
  assign at_lo     = edge_cnt == half - PRESCALE_W'(1);
  assign at_mid    = edge_cnt == half;
  assign at_hi     = edge_cnt == half + PRESCALE_W'(1);
  assign bit_done  = enable && (edge_cnt == last_edge);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt    <= '0;
      s0          <= 1'b0;
      s1          <= 1'b0;
      sampled_bit <= 1'b0;
    end else if (!enable) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= bit_done ? '0 : edge_cnt + PRESCALE_W'(1);
      if (at_lo)  s0 <= rx_in;
      if (at_mid) s1 <= rx_in;
      if (at_hi)  sampled_bit <= maj3(s0, s1, rx_in);
    end
  end

endmodule

// File: rtl/uart_rx_fsm_core.sv
// UART receive FSM: start/data/parity/stop deserialisation with
// one-cycle outcome pulses (data_valid, par_err, stp_err).
module uart_rx_fsm_core
  import uart_rx_fsm_core_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e           state;
  uart_state_e           next;
  logic [PRESCALE_W-1:0] pre_q;
  logic [PRESCALE_W-1:0] pre_eff;
  logic                  pen_q;
  logic                  ptyp_q;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_mis;
  logic                  enable;
  logic                  sampled_bit;
  logic                  bit_done;
  logic                  shift_en;
  logic                  par_chk;
  logic                  frame_end;
  logic                  last_data;
  logic                  exp_par;
  logic                  good;

  // Config is latched in IDLE; in IDLE the live inputs drive the sampler.
  assign pre_eff   = (state == IDLE) ? prescale : pre_q;
  assign enable    = (state != IDLE) || !rx_in;
  assign last_data = bit_cnt == BW'(DATA_WIDTH - 1);
  assign exp_par   = (^shreg) ^ (ptyp_q == PAR_ODD);
  assign good      = !par_mis && sampled_bit;
  assign busy      = state != IDLE;

  uart_rx_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .prescale   (pre_eff),
    .rx_in      (rx_in),
    .sampled_bit(sampled_bit),
    .bit_done   (bit_done)
  );

  always_comb begin
    next      = state;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_in) next = START;
      end
      START: begin
        if (bit_done) next = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_en = 1'b1;
          if (last_data) next = pen_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_done) begin
          par_chk = 1'b1;
          next    = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          frame_end = 1'b1;
          next      = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pre_q   <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_mis <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE) begin
        pre_q   <= prescale;
        pen_q   <= par_en;
        ptyp_q  <= par_typ;
        bit_cnt <= '0;
        par_mis <= 1'b0;
      end
      if (shift_en) begin
        shreg   <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (par_chk) par_mis <= exp_par != sampled_bit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= frame_end && good;
      par_err    <= frame_end && par_mis;
      stp_err    <= frame_end && !sampled_bit;
      if (frame_end && good) p_data <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm_core.sv
// Bench for uart_rx_fsm_core: directed frame table, random frames
// with line noise, start glitch, back-to-back and mid-frame reset.
module tb_uart_rx_fsm_core;

  localparam int DW = 8;
  localparam int PW = 6;

  typedef struct {
    logic          rx;
    logic [PW-1:0] pre;
    logic          pen;
    logic          ptyp;
    logic          busy;
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] pd;
  } vec_t;

  typedef struct {
    logic [PW-1:0] pre;
    logic          pen;
    logic          ptyp;
    logic [DW-1:0] data;
    logic          pbit;
    logic          sbit;
    int            nbit;
    int            nedge;
    bit            rnoise;
    int            gap;
    logic          dv;
    logic          pe;
    logic          se;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_in = 1'b1;
  logic [PW-1:0] prescale = 6'd8;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  vec_t          vq[$];
  logic [DW-1:0] cur_pd = '0;
  logic [DW-1:0] pend_pd = '0;
  logic          pend_dv = 0;
  logic          pend_pe = 0;
  logic          pend_se = 0;

  always #5 clk = ~clk;

  uart_rx_fsm_core #(
    .DATA_WIDTH(DW),
    .PRESCALE_W(PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .prescale  (prescale),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err),
    .busy      (busy)
  );

  task automatic check(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got {busy,dv,pe,se,pd}=%h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {busy, data_valid, par_err, stp_err, p_data};
  endfunction

  // One cycle of stimulus; any pending frame outcome lands on this cycle.
  task automatic push(input logic rxv, input logic [PW-1:0] pr,
                      input logic pn, input logic pt, input logic bz);
    vec_t v;
    v.rx = rxv; v.pre = pr; v.pen = pn; v.ptyp = pt; v.busy = bz;
    v.dv = pend_dv; v.pe = pend_pe; v.se = pend_se;
    if (pend_dv) cur_pd = pend_pd;
    v.pd = cur_pd;
    pend_dv = 0; pend_pe = 0; pend_se = 0;
    vq.push_back(v);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++)
      push(1'b1, PW'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  // Serialise a frame, one bit per prescale cycles; cut>=0 truncates it.
  task automatic add_frame(input frame_t f, input int cut);
    logic bits[12];
    int   nb, p, ne, idx;
    logic rv;
    p  = int'(f.pre);
    nb = 2 + DW + int'(f.pen);
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1+i] = f.data[i];
    if (f.pen) bits[DW+1] = f.pbit;
    bits[nb-1] = f.sbit;
    for (int b = 0; b < nb; b++) begin
      ne = f.nedge;
      if (f.rnoise) ne = ($urandom % 2) ? $urandom_range(1, p - 1) : -1;
      else if (f.nbit != b) ne = -1;
      for (int e = 0; e < p; e++) begin
        idx = b * p + e;
        if (cut >= 0 && idx >= cut) return;
        rv = (e == ne) ? ~bits[b] : bits[b];
        if (idx == 0) push(rv, f.pre, f.pen, f.ptyp, 1'b0);
        else push(rv, PW'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      end
    end
    pend_dv = f.dv; pend_pe = f.pe; pend_se = f.se; pend_pd = f.data;
    push_idle(f.gap);
  endtask

  task automatic run();
    foreach (vq[k]) begin
      @(negedge clk);
      check($sformatf("cyc%0d", cyc), outs(),
            {vq[k].busy, vq[k].dv, vq[k].pe, vq[k].se, vq[k].pd});
      rx_in = vq[k].rx; prescale = vq[k].pre;
      par_en = vq[k].pen; par_typ = vq[k].ptyp;
      cyc++;
    end
    vq.delete();
  endtask

  function automatic frame_t mk(
    input int pr, input logic pn, input logic pt, input logic [DW-1:0] d,
    input logic pb, input logic sb, input int nbit, input int nedge,
    input int gap, input logic dv, input logic pe, input logic se);
    frame_t f;
    f.pre = PW'(pr); f.pen = pn; f.ptyp = pt; f.data = d;
    f.pbit = pb; f.sbit = sb; f.nbit = nbit; f.nedge = nedge;
    f.rnoise = 0; f.gap = gap; f.dv = dv; f.pe = pe; f.se = se;
    return f;
  endfunction

  initial begin
    frame_t dir[5];
    frame_t f;
    logic   gp;
    dir[0] = mk(8,  0, 0, 8'hA5, 0, 1, -1, 0, 2, 1, 0, 0);
    dir[1] = mk(16, 1, 0, 8'h3C, 0, 1, -1, 0, 2, 1, 0, 0);
    dir[2] = mk(16, 1, 0, 8'h3C, 1, 1, -1, 0, 2, 0, 1, 0);
    dir[3] = mk(32, 1, 1, 8'h01, 0, 0, -1, 0, 3, 0, 0, 1);
    dir[4] = mk(16, 0, 0, 8'hF0, 0, 1, 4, 8, 2, 1, 0, 0);

    repeat (3) @(negedge clk);
    check("reset", outs(), 12'h000);
    rst = 1'b1;

    push_idle(2);
    foreach (dir[i]) add_frame(dir[i], -1);
    run();

    // Start glitch: low 3 clks then high; FSM gives up at end of bit.
    push(1'b0, 6'd8, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++)
      push(i < 3 ? 1'b0 : 1'b1, PW'($urandom), 1'b1, 1'b1, 1'b1);
    push_idle(2);
    add_frame(mk(8, 0, 0, 8'h55, 0, 1, -1, 0, 2, 1, 0, 0), -1);
    run();

    // Back-to-back frames, then a third frame cut by reset at cycle 40.
    add_frame(mk(8, 0, 0, 8'h12, 0, 1, -1, 0, 0, 1, 0, 0), -1);
    add_frame(mk(8, 0, 0, 8'h34, 0, 1, -1, 0, 0, 1, 0, 0), -1);
    add_frame(mk(8, 0, 0, 8'h77, 0, 1, -1, 0, 0, 1, 0, 0), 40);
    run();
    @(negedge clk);
    rst = 1'b0; rx_in = 1'b1;
    #1 check("midframe_reset", outs(), 12'h000);
    @(negedge clk);
    check("reset_hold", outs(), 12'h000);
    rst = 1'b1;
    cur_pd = '0; pend_dv = 0; pend_pe = 0; pend_se = 0;
    add_frame(mk(8, 0, 0, 8'h9C, 0, 1, -1, 0, 3, 1, 0, 0), -1);
    run();

    // Random frames with per-bit single-cycle noise and random errors.
    for (int n = 0; n < 30; n++) begin
      case ($urandom % 3)
        0:       f.pre = 6'd8;
        1:       f.pre = 6'd16;
        default: f.pre = 6'd32;
      endcase
      f.pen   = 1'($urandom);
      f.ptyp  = 1'($urandom);
      f.data  = DW'($urandom);
      gp      = (^f.data) ^ f.ptyp;
      f.pbit  = ($urandom % 4 == 0) ? ~gp : gp;
      f.sbit  = ($urandom % 5 != 0);
      f.nbit  = -1;
      f.nedge = 0;
      f.rnoise = 1;
      f.gap   = $urandom_range(0, 3);
      f.pe    = f.pen && (f.pbit != gp);
      f.se    = !f.sbit;
      f.dv    = !f.pe && !f.se;
      add_frame(f, -1);
    end
    push_idle(4);
    run();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm_core.md
Name: uart_rx_fsm_core

Overview:
- UART receiver: counterpart of the UART TX in the same UART block.
- Deserialises one frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit.
- Oversamples at a runtime prescale (8/16/32) and checks start glitch, parity and stop bit.
- Delivers the parallel byte with a one-cycle valid strobe to the system-side register/sync logic.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_W, 6, width of prescale input and edge counter

Ports:
clk  input  1  UART oversampling clock
rst  input  1  asynchronous, active-low reset
rx_in  input  1  serial line; idle high; already synchronised to clk upstream
prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
par_en  input  1  1 = frame carries a parity bit
par_typ  input  1  0 = even parity, 1 = odd parity
p_data  output  DATA_WIDTH  last correctly received data word
data_valid  output  1  one-cycle pulse: p_data updated with a good frame
par_err  output  1  one-cycle pulse: parity mismatch in the frame just ended
stp_err  output  1  one-cycle pulse: stop bit sampled 0 in the frame just ended
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset values: all outputs 0, p_data = 0, state IDLE, all counters 0.
- Timing reference: cycle 0 is the first clk in which IDLE sees rx_in = 0. That cycle is edge 0 of the start bit.
- edge_cnt runs 0..prescale-1 within each bit. bit_cnt counts bits within the frame.
- Sampling: majority vote of rx_in at edges prescale/2-1, prescale/2 and prescale/2+1 of every bit.
- Bit decision: the vote is taken at edge prescale/2+1. The state acts on it at edge prescale-1.
- States and transitions:
  - IDLE: stay while rx_in = 1. On rx_in = 0, go to START with edge_cnt = 1.
  - START: at end of bit, if the voted sample = 1 (glitch), return to IDLE with no outputs and no error pulse. Otherwise go to DATA.
  - DATA: shift each voted bit into a shift register, LSB first. After DATA_WIDTH bits, go to PARITY if par_en, else STOP.
  - PARITY: compute expected parity = XOR of data bits, inverted if par_typ = 1. Latch mismatch flag; go to STOP.
  - STOP: at end of bit, go to IDLE and raise the frame outcome outputs for exactly one cycle (next bullet).
- Frame outcome, driven in the cycle after the last stop edge:
  - data_valid = 1 and p_data loaded only if no parity mismatch and the stop sample = 1.
  - par_err = latched mismatch flag.
  - stp_err = (stop sample == 0).
  - Both errors may pulse together. A frame with any error never updates p_data.
- Latency: outcome at cycle (1+DATA_WIDTH+par_en+1)*prescale after cycle 0.
  - prescale = 8, no parity: cycle 80.
  - prescale = 8, parity: cycle 88.
- Back-to-back frames: IDLE is entered in the outcome cycle, so a start edge in that same cycle is detected normally (zero gap). The outcome pulse is not suppressed.
- p_data holds its value between frames.
- busy drops in the outcome cycle.
- prescale, par_en and par_typ are sampled only in IDLE; changes mid-frame are ignored until the next frame.
- Illegal prescale values (not 8/16/32) are unsupported; no checking is required.
- rst asserted mid-frame: immediate return to reset values; no pulses.
- The edge counter compares with prescale-1 at PRESCALE_W bits; prescale = 32 must not wrap.

Decomposition:
- Shared UART package: state encoding (IDLE, START, DATA, PARITY, STOP, 3-bit), legal prescale constants, parity-type constants. The TX side reuses the parity constants.
- One sub-module: uart_rx_sampler. It holds the edge counter, three-sample majority vote and end-of-bit strobe. Ports: clk, rst, enable, prescale, rx_in, sampled_bit, bit_done.
- FSM, bit counter, shift register and checks stay in the top module.

Test Plan:
- prescale = 8, par_en = 0, frame 0xA5: p_data = 0xA5; data_valid pulses one cycle at cycle 80; par_err = stp_err = 0; busy high cycles 1..79.
- prescale = 16, par_en = 1, par_typ = 0, frame 0x3C with parity bit 0: p_data = 0x3C, data_valid at cycle 176. Repeat with parity bit 1: par_err pulse, no data_valid, p_data unchanged.
- prescale = 32, par_en = 1, par_typ = 1, frame 0x01 with parity 0 and stop bit 0: stp_err pulses, no par_err, no data_valid; counter reaches 31 without wrap.
- Start glitch: rx_in low for 3 clks then high, prescale = 8: FSM returns to IDLE after 8 cycles; no outputs pulse. A following valid 0x55 frame is received correctly.
- Noise: single-cycle inversion of rx_in at edge prescale/2 inside data bit 3 of 0xF0: majority vote rejects it; p_data = 0xF0.
- Back-to-back: frames 0x12 then 0x34 with zero idle gap, then rst pulled low at cycle 40 of a third frame: two data_valid pulses 80 cycles apart; after reset all outputs are 0 and a following frame is received correctly.
